// File: rtl/string_char_streamer.sv
// Streams the characters of one string-ROM entry, leftmost first, over a valid/ready channel.
// Optional macro STRING_STREAM_TRIM_EN stops each string at its rightmost non-blank character.
module string_char_streamer #(
   parameter int unsigned STRING_NUM = 13,
   parameter int unsigned MAX_CHAR   = 11,
   parameter int unsigned CHAR_WIDTH = 5,
   parameter int unsigned SPACE_CODE = 31
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 req_valid,
   input  logic [$clog2(STRING_NUM+1)-1:0]      req_idx,
   output logic                                 req_ready,
   output logic [$clog2(STRING_NUM+1)-1:0]      rom_addr,
   input  logic [CHAR_WIDTH*MAX_CHAR-1:0]       rom_data,
   output logic                                 ch_valid,
   input  logic                                 ch_ready,
   output logic [CHAR_WIDTH-1:0]                ch_code,
   output logic [$clog2(MAX_CHAR)-1:0]          ch_pos,
   output logic                                 ch_last,
   output logic                                 err_oob,
   output logic                                 busy
);

   localparam int unsigned IDX_W  = $clog2(STRING_NUM + 1);
   localparam int unsigned POS_W  = $clog2(MAX_CHAR);
   localparam int unsigned DATA_W = CHAR_WIDTH * MAX_CHAR;
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(MAX_CHAR - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_buf;
   logic [POS_W-1:0]    r_pos;
   logic [POS_W-1:0]    r_last_pos;
   logic [IDX_W-1:0]    r_rom_addr;
   logic                r_err_oob;
   logic [POS_W-1:0]    w_fetch_last;
   logic [DATA_W-1:0]   w_shift;
   logic                w_accept;
   logic                w_in_range;
   logic                w_hs;
   logic                w_last;

   assign w_accept   = req_valid && (r_state == IDLE);
   assign w_in_range = req_idx < IDX_W'(STRING_NUM);
   assign w_hs       = (r_state == EMIT) && ch_ready;
   assign w_last     = (r_pos == r_last_pos);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept && w_in_range) w_state_nxt = FETCH;
         FETCH:   w_state_nxt = EMIT;
         EMIT:    if (w_hs && w_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef STRING_STREAM_TRIM_EN
   // Rightmost non-blank position; an all-blank string collapses to position 0
   always_comb begin
      w_fetch_last = '0;
      for (int i = 0; i < int'(MAX_CHAR); i++) begin
         if (rom_data[DATA_W-1-i*CHAR_WIDTH -: CHAR_WIDTH] != CHAR_WIDTH'(SPACE_CODE))
            w_fetch_last = POS_W'(i);
      end
   end
`else
   assign w_fetch_last = LAST_POS;
`endif

   // Datapath: ROM address, character buffer, position and error pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rom_addr <= '0;
         r_buf      <= '0;
         r_pos      <= '0;
         r_last_pos <= LAST_POS;
         r_err_oob  <= 1'b0;
      end else begin
         r_err_oob <= w_accept && !w_in_range;
         if (w_accept && w_in_range) r_rom_addr <= req_idx;
         if (r_state == FETCH) begin
            r_buf      <= rom_data;
            r_pos      <= '0;
            r_last_pos <= w_fetch_last;
         end else if (w_hs && !w_last) begin
            r_pos <= r_pos + POS_W'(1);
         end
      end
   end

   // Shift the selected character into the top slot of the buffer
   assign w_shift   = r_buf << (32'(r_pos) * CHAR_WIDTH);

   assign req_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign ch_valid  = (r_state == EMIT);
   assign ch_code   = w_shift[DATA_W-1 -: CHAR_WIDTH];
   assign ch_pos    = r_pos;
   assign ch_last   = ch_valid && w_last;
   assign rom_addr  = r_rom_addr;
   assign err_oob   = r_err_oob;

endmodule

// File: tb/tb_string_char_streamer.sv
// Scoreboard bench for string_char_streamer with a behavioural string ROM.
module tb_string_char_streamer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [3:0]  req_idx;
   logic        req_ready;
   logic [3:0]  rom_addr;
   logic [54:0] rom_data;
   logic        ch_valid;
   logic        ch_ready;
   logic [4:0]  ch_code;
   logic [3:0]  ch_pos;
   logic        ch_last;
   logic        err_oob;
   logic        busy;

   logic [4:0]  rom_tab [13][11];
   logic        rom_blank;

   typedef struct {
      int code;
      int pos;
      int last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_mis;
   int   exp_addr;

   string_char_streamer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_idx   (req_idx),
      .req_ready (req_ready),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ch_valid  (ch_valid),
      .ch_ready  (ch_ready),
      .ch_code   (ch_code),
      .ch_pos    (ch_pos),
      .ch_last   (ch_last),
      .err_oob   (err_oob),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ROM, leftmost character in the MSBs
   always_comb begin
      rom_data = '0;
      for (int i = 0; i < 11; i++) begin
         if (rom_blank)          rom_data[54-5*i -: 5] = 5'd31;
         else if (rom_addr < 13) rom_data[54-5*i -: 5] = rom_tab[rom_addr][i];
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int char_of(input int s, input int i);
      if (rom_blank) return 31;
      return 32'(rom_tab[s][i]);
   endfunction

   function automatic int exp_last(input int s);
      int l;
`ifdef STRING_STREAM_TRIM_EN
      l = 0;
      for (int i = 0; i < 11; i++)
         if (char_of(s, i) != 31) l = i;
`else
      l = 10;
`endif
      return l;
   endfunction

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_valid"}, 32'(ch_valid), 0);
      check_eq({tag, "_code"},  32'(ch_code),  0);
      check_eq({tag, "_pos"},   32'(ch_pos),   0);
      check_eq({tag, "_last"},  32'(ch_last),  0);
      check_eq({tag, "_oob"},   32'(err_oob),  0);
      check_eq({tag, "_busy"},  32'(busy),     0);
      check_eq({tag, "_addr"},  32'(rom_addr), 0);
   endtask

   // One request: push expectations, drive it, then consume the stream
   task automatic stream(input int idx, input int stall_pos, input int stall_n,
                         input int rst_pos, input bit glitch, input bit rnd);
      int   last;
      int   n;
      int   stalls;
      bit   done;
      bit   fin;
      bit   stall;
      exp_t e;
      last = exp_last(idx);
      for (int i = 0; i <= last; i++) begin
         e.code = char_of(idx, i);
         e.pos  = i;
         e.last = (i == last) ? 1 : 0;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_idx   = 4'(idx);
      @(posedge clk); #1;
      req_valid = 1'b0;
      exp_addr  = idx;
      @(negedge clk);
      check_eq("fetch_valid", 32'(ch_valid), 0);
      check_eq("fetch_busy",  32'(busy), 1);
      check_eq("fetch_addr",  32'(rom_addr), exp_addr);
      @(negedge clk);
      check_eq("first_valid", 32'(ch_valid), 1);
      n = 0; stalls = 0; done = 1'b0; fin = 1'b0;
      while (!done) begin
         if (fin) begin
            check_eq("ready_after_last", 32'(req_ready), 1);
            check_eq("valid_after_last", 32'(ch_valid), 0);
            done = 1'b1;
         end else if (n > 200) begin
            check_eq("stream_timeout", 0, 1);
            done = 1'b1;
         end else if (!ch_valid) begin
            check_eq("valid_dropped", 0, 1);
            done = 1'b1;
         end else if (sb.size() == 0) begin
            check_eq("extra_char", 1, 0);
            done = 1'b1;
         end else if (rst_pos >= 0 && 32'(ch_pos) == rst_pos) begin
            rst_n = 1'b0;
            @(negedge clk);
            check_idle_zero("abort");
            exp_addr = 0;
            sb.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            check_eq("abort_ready", 32'(req_ready), 1);
            check_eq("abort_novalid", 32'(ch_valid), 0);
            done = 1'b1;
         end else begin
            stall = (stall_pos >= 0 && 32'(ch_pos) == stall_pos && stalls < stall_n) ||
                    (rnd && $urandom_range(0, 2) == 0);
            ch_ready = !stall;
            e = sb[0];
            check_eq("ch_code", 32'(ch_code), e.code);
            check_eq("ch_pos",  32'(ch_pos),  e.pos);
            check_eq("ch_last", 32'(ch_last), e.last);
            if (stall) begin
               stalls++;
            end else begin
               void'(sb.pop_front());
               if (e.last == 1) fin = 1'b1;
            end
            if (glitch) rom_blank = ~rom_blank;
         end
         if (!done) begin
            @(negedge clk);
            n++;
         end
      end
      ch_ready  = 1'b1;
      rom_blank = 1'b0;
   endtask

   task automatic oob(input int idx);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_idx   = 4'(idx);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("oob_pulse", 32'(err_oob),   1);
      check_eq("oob_valid", 32'(ch_valid),  0);
      check_eq("oob_ready", 32'(req_ready), 1);
      check_eq("oob_addr",  32'(rom_addr),  exp_addr);
      @(negedge clk);
      check_eq("oob_clear", 32'(err_oob),   0);
      check_eq("oob_idle",  32'(busy),      0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0; n_mis = 0; exp_addr = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_idx = '0; ch_ready = 1'b1; rom_blank = 1'b0;
      for (int s = 0; s < 13; s++)
         for (int i = 0; i < 11; i++)
            rom_tab[s][i] = (i > 10 - (s % 4)) ? 5'd31 : 5'((s * 3 + i * 7) % 31);
      begin
         int s0 [11] = '{6, 0, 12, 4, 31, 19, 8, 12, 4, 26, 31};
         int s12[11] = '{8, 13, 18, 19, 17, 20, 2, 19, 8, 14, 13};
         for (int i = 0; i < 11; i++) begin
            rom_tab[0][i]  = 5'(s0[i]);
            rom_tab[7][i]  = 5'd27;
            rom_tab[12][i] = 5'(s12[i]);
         end
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", 32'(req_ready), 1);

      stream(0,  -1, 0, -1, 1'b0, 1'b0);
      stream(12,  2, 3, -1, 1'b0, 1'b0);
      oob(13);
      oob(15);
      stream(7,  -1, 0,  5, 1'b0, 1'b0);
      stream(7,  -1, 0, -1, 1'b0, 1'b0);
      stream(3,  -1, 0, -1, 1'b1, 1'b0);
      stream(9,  -1, 0, -1, 1'b0, 1'b1);
      stream(1,  -1, 0, -1, 1'b0, 1'b1);
      rom_blank = 1'b1;
      stream(5,  -1, 0, -1, 1'b0, 1'b0);
      stream(12, -1, 0, -1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
